// File: rtl/alu_pkg.sv
// Shared types for the RV32I decode stage: ALU op codes, operand selects,
// opcode constants and the decoded bundle handed to execute.
package alu_pkg;

    localparam int DEC_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_OR   = 4'd7,
        ALU_AND  = 4'd8,
        ALU_SUB  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } src_a_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e               alu_op;
        src_a_sel_e            src_a_sel;
        logic                  src_b_sel;
        logic [DEC_XLEN-1:0]   imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [DEC_XLEN-1:0]   pc;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  illegal;
    } decode_bundle_t;

    // funct3 -> ALU op for OP / OP-IMM; alt picks SUB/SRA where it applies
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I decode of one instruction word into a bundle.
module rv32_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0]          i_instr,
    input  logic [DEC_XLEN-1:0]  i_pc,
    output decode_bundle_t       o_bundle
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_ill;
    decode_bundle_t w_b;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u  = {i_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // opcode decode; illegal encodings fall back to a harmless ADD with no side effects
    always_comb begin
        w_b           = '0;
        w_b.alu_op    = ALU_ADD;
        w_b.src_a_sel = SRC_A_RS1;
        w_b.rs1       = i_instr[19:15];
        w_b.rs2       = i_instr[24:20];
        w_b.rd        = i_instr[11:7];
        w_b.pc        = i_pc;
        w_ill         = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_b.alu_op    = f3_to_alu(w_f3, w_f7 == F7_ALT);
                w_b.reg_write = 1'b1;
                if (!(w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                    w_ill = 1'b1;
            end
            OPC_OP_IMM: begin
                w_b.src_b_sel = 1'b1;
                w_b.reg_write = 1'b1;
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_b.imm    = {27'b0, i_instr[24:20]};
                    w_b.alu_op = f3_to_alu(w_f3, w_f7 == F7_ALT);
                    if (!(w_f7 == F7_BASE || (w_f7 == F7_ALT && w_f3 == 3'b101)))
                        w_ill = 1'b1;
                end else begin
                    w_b.imm    = w_imm_i;
                    w_b.alu_op = f3_to_alu(w_f3, 1'b0);
                end
            end
            OPC_LUI: begin
                w_b.src_a_sel = SRC_A_ZERO;
                w_b.src_b_sel = 1'b1;
                w_b.imm       = w_imm_u;
                w_b.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_b.src_a_sel = SRC_A_PC;
                w_b.src_b_sel = 1'b1;
                w_b.imm       = w_imm_u;
                w_b.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                w_b.src_b_sel = 1'b1;
                w_b.imm       = w_imm_i;
                w_b.mem_read  = 1'b1;
                w_b.reg_write = 1'b1;
            end
            OPC_STORE: begin
                w_b.src_b_sel = 1'b1;
                w_b.imm       = w_imm_s;
                w_b.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_b.imm    = w_imm_b;
                w_b.branch = 1'b1;
                case (w_f3)
                    3'b000, 3'b001: w_b.alu_op = ALU_SUB;
                    3'b100, 3'b101: w_b.alu_op = ALU_SLT;
                    3'b110, 3'b111: w_b.alu_op = ALU_SLTU;
                    default:        w_ill      = 1'b1;
                endcase
            end
            OPC_JAL: begin
                w_b.src_a_sel = SRC_A_PC;
                w_b.src_b_sel = 1'b1;
                w_b.imm       = w_imm_j;
                w_b.jump      = 1'b1;
                w_b.reg_write = 1'b1;
            end
            OPC_JALR: begin
                w_b.src_b_sel = 1'b1;
                w_b.imm       = w_imm_i;
                w_b.jump      = 1'b1;
                w_b.reg_write = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_b.alu_op    = ALU_ADD;
            w_b.reg_write = 1'b0;
            w_b.mem_read  = 1'b0;
            w_b.mem_write = 1'b0;
            w_b.branch    = 1'b0;
            w_b.jump      = 1'b0;
        end
        w_b.illegal = w_ill;
    end

    assign o_bundle = w_b;

endmodule

// File: rtl/id_ex_alu_decode.sv
// Decode pipeline stage: one register slice with valid/ready and flush
// around the combinational RV32I decoder.
module id_ex_alu_decode
    import alu_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic [1:0]      out_src_a_sel,
    output logic            out_src_b_sel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    logic           r_valid;
    decode_bundle_t r_bundle;
    decode_bundle_t w_dec;
    logic           w_in_ready;

    rv32_decode_comb u_dec (
        .i_instr  (in_instr),
        .i_pc     (in_pc),
        .o_bundle (w_dec)
    );

    assign w_in_ready = !r_valid || out_ready;

    // valid bit: flush wins over everything, otherwise reload whenever the slot frees up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_valid <= 1'b0;
        else if (flush)
            r_valid <= 1'b0;
        else if (w_in_ready)
            r_valid <= in_valid;
    end

    // data slice: capture on every input transfer, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bundle           <= '0;
            r_bundle.alu_op    <= ALU_ADD;
            r_bundle.src_a_sel <= SRC_A_RS1;
            r_bundle.pc        <= RESET_PC_TAG;
        end else if (in_valid && w_in_ready) begin
            r_bundle <= w_dec;
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_valid;
    assign out_alu_op    = r_bundle.alu_op;
    assign out_src_a_sel = r_bundle.src_a_sel;
    assign out_src_b_sel = r_bundle.src_b_sel;
    assign out_imm       = r_bundle.imm;
    assign out_rs1       = r_bundle.rs1;
    assign out_rs2       = r_bundle.rs2;
    assign out_rd        = r_bundle.rd;
    assign out_pc        = r_bundle.pc;
    assign out_reg_write = r_bundle.reg_write;
    assign out_mem_read  = r_bundle.mem_read;
    assign out_mem_write = r_bundle.mem_write;
    assign out_branch    = r_bundle.branch;
    assign out_jump      = r_bundle.jump;
    assign out_illegal   = r_bundle.illegal;

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Scoreboard bench for the decode stage: hand-derived expectations are queued
// on each input transfer and compared while the bundle is presented.
module tb_id_ex_alu_decode;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    localparam logic [5:0] RW = 6'b100000;
    localparam logic [5:0] MR = 6'b010000;
    localparam logic [5:0] MW = 6'b001000;
    localparam logic [5:0] BR = 6'b000100;
    localparam logic [5:0] JP = 6'b000010;
    localparam logic [5:0] IL = 6'b000001;

    localparam logic [3:0] M_IMM = 4'b0001;
    localparam logic [3:0] M_RS  = 4'b0010;
    localparam logic [3:0] M_RD  = 4'b0100;
    localparam logic [3:0] M_SEL = 4'b1000;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [1:0]  sa;
        logic        sb;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  flags;
        logic [3:0]  mask;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_src_a_sel;
    logic        out_src_b_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t vt[19];
    exp_t e_nil;
    logic acc;

    id_ex_alu_decode #(.XLEN(32), .RESET_PC_TAG(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_src_a_sel (out_src_a_sel),
        .out_src_b_sel (out_src_b_sel),
        .out_imm       (out_imm),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_pc        (out_pc),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_branch    (out_branch),
        .out_jump      (out_jump),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [3:0] alu, input logic [1:0] sa,
                                input logic sb, input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [5:0] flags,
                                input logic [3:0] mask);
        exp_t e;
        e.instr = instr; e.alu = alu; e.sa = sa; e.sb = sb; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.flags = flags; e.mask = mask; e.pc = '0;
        return e;
    endfunction

    task automatic cmp_bundle(input exp_t e);
        chk($sformatf("alu_op[%h]", e.instr), {28'b0, out_alu_op}, {28'b0, e.alu});
        chk($sformatf("flags[%h]", e.instr),
            {26'b0, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal},
            {26'b0, e.flags});
        chk($sformatf("pc[%h]", e.instr), out_pc, e.pc);
        if (e.mask[0]) chk($sformatf("imm[%h]", e.instr), out_imm, e.imm);
        if (e.mask[1]) chk($sformatf("rs[%h]", e.instr), {22'b0, out_rs1, out_rs2}, {22'b0, e.rs1, e.rs2});
        if (e.mask[2]) chk($sformatf("rd[%h]", e.instr), {27'b0, out_rd}, {27'b0, e.rd});
        if (e.mask[3]) chk($sformatf("sel[%h]", e.instr), {29'b0, out_src_a_sel, out_src_b_sel}, {29'b0, e.sa, e.sb});
    endtask

    // one cycle: drive at negedge, check presented bundle, update scoreboard
    task automatic step(input logic iv, input exp_t e, input logic [31:0] pc,
                        input logic ordy, input logic fl, output logic accepted);
        exp_t en;
        @(negedge clk);
        out_ready = ordy;
        flush     = fl;
        in_valid  = iv;
        in_instr  = e.instr;
        in_pc     = pc;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() == 0) || ordy});
        if (out_valid && q.size() > 0) cmp_bundle(q[0]);
        accepted = iv && in_ready;
        if (fl) begin
            q.delete();
        end else begin
            if (out_valid && ordy && q.size() > 0) void'(q.pop_front());
            if (accepted) begin
                en = e;
                en.pc = pc;
                q.push_back(en);
            end
        end
    endtask

    initial begin
        vt[0]  = mk(32'h002081B3, 4'd0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2, 5'd3, RW,      M_RS | M_RD | M_SEL);
        vt[1]  = mk(32'h402081B3, 4'd9, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2, 5'd3, RW,      M_RS | M_RD | M_SEL);
        vt[2]  = mk(32'h40335293, 4'd6, 2'd0, 1'b1, 32'h3,        5'd6, 5'd3, 5'd5, RW,      M_IMM | M_RS | M_RD | M_SEL);
        vt[3]  = mk(32'h123450B7, 4'd0, 2'd2, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd1, RW,      M_IMM | M_RD | M_SEL);
        vt[4]  = mk(32'h0020C463, 4'd2, 2'd0, 1'b0, 32'h8,        5'd1, 5'd2, 5'd0, BR,      M_IMM | M_RS | M_SEL);
        vt[5]  = mk(32'hFFFFFFFF, 4'd0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, IL,      4'b0);
        vt[6]  = mk(32'h00412283, 4'd0, 2'd0, 1'b1, 32'h4,        5'd2, 5'd0, 5'd5, RW | MR, M_IMM | M_RD | M_SEL);
        vt[7]  = mk(32'hFE20AE23, 4'd0, 2'd0, 1'b1, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, MW,      M_IMM | M_RS | M_SEL);
        vt[8]  = mk(32'h010000EF, 4'd0, 2'd1, 1'b1, 32'h10,       5'd0, 5'd0, 5'd1, RW | JP, M_IMM | M_RD | M_SEL);
        vt[9]  = mk(32'h00008067, 4'd0, 2'd0, 1'b1, 32'h0,        5'd1, 5'd0, 5'd0, RW | JP, M_IMM | M_RD | M_SEL);
        vt[10] = mk(32'h00001117, 4'd0, 2'd1, 1'b1, 32'h1000,     5'd0, 5'd0, 5'd2, RW,      M_IMM | M_RD | M_SEL);
        vt[11] = mk(32'h202081B3, 4'd0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd3, IL,      M_RD);
        vt[12] = mk(32'h0020A463, 4'd0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, IL,      4'b0);
        vt[13] = mk(32'h40309293, 4'd0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0, IL,      4'b0);
        vt[14] = mk(32'h0020F463, 4'd3, 2'd0, 1'b0, 32'h8,        5'd1, 5'd2, 5'd0, BR,      M_IMM | M_RS | M_SEL);
        vt[15] = mk(32'h00208463, 4'd9, 2'd0, 1'b0, 32'h8,        5'd1, 5'd2, 5'd0, BR,      M_IMM | M_RS | M_SEL);
        vt[16] = mk(32'hFFF00093, 4'd0, 2'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, RW,      M_IMM | M_RD | M_SEL);
        vt[17] = mk(32'h0020E1B3, 4'd7, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2, 5'd3, RW,      M_RS | M_RD | M_SEL);
        vt[18] = mk(32'h00335293, 4'd5, 2'd0, 1'b1, 32'h3,        5'd6, 5'd3, 5'd5, RW,      M_IMM | M_RS | M_RD | M_SEL);
        e_nil  = mk(32'h00000013, 4'd0, 2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 6'b0, 4'b0);

        // reset values
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_alu_op", {28'b0, out_alu_op}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, RST_PC);
        chk("rst_flags", {26'b0, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back with the sink always ready
        step(1'b1, vt[0], 32'h100, 1'b1, 1'b0, acc);
        step(1'b1, vt[1], 32'h104, 1'b1, 1'b0, acc);
        step(1'b1, vt[2], 32'h108, 1'b1, 1'b0, acc);
        step(1'b0, e_nil, 32'h0,   1'b1, 1'b0, acc);
        step(1'b0, e_nil, 32'h0,   1'b1, 1'b0, acc);

        // stall for three cycles, then async reset while still stalled
        step(1'b1, vt[3], 32'h10C, 1'b0, 1'b0, acc);
        for (int k = 0; k < 3; k++) step(1'b1, vt[0], 32'h200, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_pc", out_pc, RST_PC);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // whole table with a randomly stalling sink
        for (int i = 0; i < 19; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 30 && !acc; t++)
                step(1'b1, vt[i], 32'h1000 + 32'(i) * 4, ($urandom_range(0, 3) != 0), 1'b0, acc);
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        end
        for (int t = 0; t < 50 && q.size() > 0; t++) step(1'b0, e_nil, 32'h0, 1'b1, 1'b0, acc);
        chk("drain_timeout", q.size(), 32'd0);
        step(1'b0, e_nil, 32'h0, 1'b1, 1'b0, acc);

        // flush a held illegal bundle while the stage is stalled
        step(1'b1, vt[5], 32'h300, 1'b0, 1'b0, acc);
        step(1'b0, e_nil, 32'h0,   1'b0, 1'b0, acc);
        step(1'b1, vt[0], 32'h304, 1'b0, 1'b1, acc);
        step(1'b0, e_nil, 32'h0,   1'b1, 1'b0, acc);

        // flush the instruction accepted in the same cycle
        step(1'b1, vt[1], 32'h400, 1'b1, 1'b0, acc);
        step(1'b1, vt[2], 32'h404, 1'b1, 1'b1, acc);
        step(1'b0, e_nil, 32'h0,   1'b1, 1'b0, acc);
        step(1'b0, e_nil, 32'h0,   1'b1, 1'b0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
